// File: rtl/uart_cmd_if.sv
// Command/response framing between a byte-oriented UART wrapper and control logic.
// Three received bytes (MSB first) form one 24-bit command; one response byte is sent per request.
module uart_cmd_if #(
    parameter int unsigned     TO_W        = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rdy,
    output logic        clr_rdy,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frame_err,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_e;

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - TO_W'(1);

    logic [1:0]      bcnt_q,      bcnt_d;
    logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
    logic [23:0]     cmd_q,       cmd_d;
    logic            cmd_rdy_q,   cmd_rdy_d;
    logic            clr_rdy_q,   clr_rdy_d;
    logic            frame_err_q, frame_err_d;
    logic            capture_s;

    tx_state_e       tx_state_q;
    logic [7:0]      tx_data_q;
    logic            trmt_q;
    logic            resp_sent_q;
    logic            tx_done_prev_q;

    // Receive framing: byte capture, command assembly and inter-byte timeout
    always_comb begin
        // clr_rdy_q blocks the cycle where the UART has not yet dropped rdy;
        // clr_cmd_rdy defers a byte by one cycle so the acknowledge wins.
        capture_s   = rdy & ~clr_rdy_q & ~cmd_rdy_q & ~clr_cmd_rdy;
        bcnt_d      = bcnt_q;
        to_cnt_d    = to_cnt_q;
        cmd_d       = cmd_q;
        clr_rdy_d   = 1'b0;
        frame_err_d = 1'b0;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end else begin
            cmd_rdy_d = cmd_rdy_q;
        end

        if (capture_s) begin
            clr_rdy_d = 1'b1;
            to_cnt_d  = '0;
            case (bcnt_q)
                2'd0: begin
                    cmd_d[23:16] = rx_data;
                    bcnt_d       = 2'd1;
                end
                2'd1: begin
                    cmd_d[15:8] = rx_data;
                    bcnt_d      = 2'd2;
                end
                2'd2: begin
                    cmd_d[7:0] = rx_data;
                    bcnt_d     = 2'd0;
                    cmd_rdy_d  = 1'b1;
                end
                default: begin
                    bcnt_d = 2'd0;
                end
            endcase
        end else if (bcnt_q != 2'd0) begin
            if (to_cnt_q == TO_LAST) begin
                bcnt_d      = 2'd0;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Receive-side state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q      <= 2'd0;
            to_cnt_q    <= '0;
            cmd_q       <= 24'd0;
            cmd_rdy_q   <= 1'b0;
            clr_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            to_cnt_q    <= to_cnt_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            clr_rdy_q   <= clr_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Transmit FSM: launch one response, wait for rising tx_done, report completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q     <= TX_IDLE;
            tx_data_q      <= 8'd0;
            trmt_q         <= 1'b0;
            resp_sent_q    <= 1'b0;
            tx_done_prev_q <= 1'b0;
        end else begin
            tx_done_prev_q <= tx_done;
            trmt_q         <= 1'b0;
            resp_sent_q    <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    // A request coinciding with the completion pulse waits a cycle
                    if (send_resp && !resp_sent_q) begin
                        tx_data_q  <= resp;
                        trmt_q     <= 1'b1;
                        tx_state_q <= TX_BUSY;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                TX_BUSY: begin
                    if (tx_done && !tx_done_prev_q) begin
                        resp_sent_q <= 1'b1;
                        tx_state_q  <= TX_IDLE;
                    end else begin
                        tx_state_q <= TX_BUSY;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign clr_rdy   = clr_rdy_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;
    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_if.sv
// Directed bench for uart_cmd_if: table of command frames plus hand-written
// sequences for backpressure, timeout, transmit handshake, loopback and reset.
module tb_uart_cmd_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rdy;
    logic        clr_rdy;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frame_err;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    always #5 clk = ~clk;

    uart_cmd_if #(
        .TO_W        (24),
        .TIMEOUT_CYC (24'd16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rdy         (rdy),
        .clr_rdy     (clr_rdy),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frame_err   (frame_err),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] exp_cmd;
    } frame_t;

    frame_t tbl [4];
    int     vec_cnt = 0;
    int     err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // UART side: hold rdy until clr_rdy, then drop it; returns one cycle after the pulse
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited  = 0;
        rx_data = b;
        rdy     = 1'b1;
        @(negedge clk);
        while (!clr_rdy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("clr_rdy_seen", {31'd0, clr_rdy}, 32'd1);
        rdy = 1'b0;
        @(negedge clk);
        check("clr_rdy_width", {31'd0, clr_rdy}, 32'd0);
    endtask

    task automatic ack_cmd();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [23:0] exp);
        send_byte(b0);
        send_byte(b1);
        check("cmd_rdy_early", {31'd0, cmd_rdy}, 32'd0);
        send_byte(b2);
        check("cmd_rdy_set", {31'd0, cmd_rdy}, 32'd1);
        check("cmd_value", {8'd0, cmd}, {8'd0, exp});
    endtask

    // Loopback: response goes out through TX and the UART echoes it back into RX
    task automatic loop_byte(input logic [7:0] b);
        logic [7:0] wire_byte;
        resp      = b;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("lb_trmt", {31'd0, trmt}, 32'd1);
        wire_byte = tx_data;
        check("lb_tx_data", {24'd0, wire_byte}, {24'd0, b});
        tick(3);
        tx_done = 1'b1;
        @(negedge clk);
        check("lb_resp_sent", {31'd0, resp_sent}, 32'd1);
        tx_done = 1'b0;
        send_byte(wire_byte);
    endtask

    initial begin
        int fe_cnt;
        int fe_at;
        int seen;

        tbl[0] = '{8'hA5, 8'h12, 8'h34, 24'hA51234};
        tbl[1] = '{8'hFF, 8'h00, 8'hFF, 24'hFF00FF};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 24'h000000};
        tbl[3] = '{8'h5A, 8'hC3, 8'h81, 24'h5AC381};

        rst_n = 1'b0; rx_data = 8'd0; rdy = 1'b0; tx_done = 1'b0;
        clr_cmd_rdy = 1'b0; resp = 8'd0; send_resp = 1'b0;
        tick(2);
        check("reset_cmd", {8'd0, cmd}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check("reset_flags", {27'd0, clr_rdy, trmt, cmd_rdy, frame_err, resp_sent}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].exp_cmd);
            ack_cmd();
        end

        // Backpressure: a byte offered while a command is pending waits for the acknowledge
        send_frame(8'hA5, 8'h12, 8'h34, 24'hA51234);
        rx_data = 8'h77;
        rdy     = 1'b1;
        seen    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (clr_rdy) seen++;
        end
        check("bp_no_clr_rdy", seen, 0);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("bp_cmd_rdy_low", {31'd0, cmd_rdy}, 32'd0);
        check("bp_ack_priority", {31'd0, clr_rdy}, 32'd0);
        @(negedge clk);
        check("bp_capture", {31'd0, clr_rdy}, 32'd1);
        check("bp_cmd_top", {8'd0, cmd}, {8'd0, 24'h771234});
        rdy = 1'b0;
        tick(20);

        // Inter-byte timeout after a single byte
        send_byte(8'h01);
        fe_cnt = 0;
        fe_at  = 0;
        for (int i = 2; i <= 22; i++) begin
            @(negedge clk);
            if (frame_err) begin
                fe_cnt++;
                fe_at = i;
            end
        end
        check("to_err_count", fe_cnt, 1);
        check("to_err_cycle", fe_at, 16);
        send_frame(8'hBE, 8'hEF, 8'h00, 24'hBEEF00);
        ack_cmd();

        // Byte arriving on the expiry cycle is kept and suppresses the error
        send_byte(8'hC1);
        tick(14);
        rx_data = 8'hD2;
        rdy     = 1'b1;
        @(negedge clk);
        check("to_race_capture", {31'd0, clr_rdy}, 32'd1);
        check("to_race_no_err", {31'd0, frame_err}, 32'd0);
        rdy = 1'b0;
        @(negedge clk);
        check("to_race_no_err_late", {31'd0, frame_err}, 32'd0);
        send_byte(8'hE3);
        check("to_race_cmd", {8'd0, cmd}, {8'd0, 24'hC1D2E3});
        check("to_race_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        ack_cmd();

        // Transmit handshake
        resp      = 8'h5A;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("tx_trmt", {31'd0, trmt}, 32'd1);
        check("tx_data", {24'd0, tx_data}, 32'h5A);
        @(negedge clk);
        check("tx_trmt_width", {31'd0, trmt}, 32'd0);
        resp      = 8'h11;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (trmt) seen++;
            @(negedge clk);
        end
        check("tx_busy_no_trmt", seen, 0);
        check("tx_busy_hold", {24'd0, tx_data}, 32'h5A);
        check("tx_no_early_sent", {31'd0, resp_sent}, 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        check("tx_resp_sent", {31'd0, resp_sent}, 32'd1);
        @(negedge clk);
        check("tx_resp_sent_width", {31'd0, resp_sent}, 32'd0);
        tx_done = 1'b0;
        tick(2);

        // Request raised alongside completion is taken one cycle after the pulse
        resp      = 8'h66;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        tick(2);
        resp      = 8'h42;
        send_resp = 1'b1;
        tx_done   = 1'b1;
        @(negedge clk);
        check("tx_race_sent", {31'd0, resp_sent}, 32'd1);
        check("tx_race_no_trmt", {31'd0, trmt}, 32'd0);
        @(negedge clk);
        check("tx_race_wait", {31'd0, trmt}, 32'd0);
        @(negedge clk);
        send_resp = 1'b0;
        check("tx_race_trmt", {31'd0, trmt}, 32'd1);
        check("tx_race_data", {24'd0, tx_data}, 32'h42);
        tx_done = 1'b0;
        tick(2);
        tx_done = 1'b1;
        @(negedge clk);
        check("tx_race_done", {31'd0, resp_sent}, 32'd1);
        tx_done = 1'b0;
        tick(2);

        // Loopback of three frames through TX into RX
        for (int f = 0; f < 3; f++) begin
            loop_byte(tbl[f + 1].b0);
            loop_byte(tbl[f + 1].b1);
            loop_byte(tbl[f + 1].b2);
            check("lb_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
            check("lb_cmd", {8'd0, cmd}, {8'd0, tbl[f + 1].exp_cmd});
            ack_cmd();
        end

        // Asynchronous reset mid-frame and mid-transmission
        send_byte(8'h9A);
        resp      = 8'h3C;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("rst_pre_trmt", {31'd0, trmt}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_cmd", {8'd0, cmd}, 32'd0);
        check("rst_async_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_async_flags", {27'd0, clr_rdy, trmt, cmd_rdy, frame_err, resp_sent}, 32'd0);
        tick(2);
        rst_n   = 1'b1;
        tx_done = 1'b1;
        seen    = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_sent) seen++;
        end
        check("rst_no_resp_sent", seen, 0);
        tx_done = 1'b0;
        send_frame(8'h12, 8'h34, 8'h56, 24'h123456);
        ack_cmd();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
